// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver/transmitter types and constants
package uart_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int DEFAULT_TICK_DIV = 27;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: free-running oversample tick, one pulse every TICK_DIV clocks
module uart_tick_gen
  import uart_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic Clock,
  input  logic Reset_n,
  output logic Tick
);
  localparam int W = $clog2(TICK_DIV + 1);
  logic [W-1:0] divCnt;
  assign Tick = divCnt == W'(TICK_DIV - 1);
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) divCnt <= '0;
    else divCnt <= Tick ? '0 : divCnt + 1'b1;
endmodule

// File: rtl/uart_word_rx.sv
// uart_word_rx: 8N1 UART receiver pairing bytes (low first) into 16-bit words
module uart_word_rx
  import uart_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int GAP_BITS = 32
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Rx,
  input  logic        Ack,
  output logic        Valid,
  output logic [15:0] DataOut,
  output logic        FrameError,
  output logic        Overrun
);
  localparam int GAP_TICKS = GAP_BITS * OVERSAMPLE;
  localparam int GW = $clog2(GAP_TICKS + 1);
  rx_state_t state, stateNext;
  logic rxMeta, rxSync, armed, pending, tick;
  logic [1:0] syncFill;
  logic [3:0] tickCnt;
  logic [2:0] bitCnt;
  logic [7:0] shiftReg, lowByte;
  logic [GW-1:0] gapCnt;
  logic startDet, sampleNow, stopOk, stopBad, wordDone, gapExpired;
  uart_tick_gen #(.TICK_DIV(TICK_DIV)) tickGen (.Clock(Clock), .Reset_n(Reset_n), .Tick(tick));
  always_comb begin
    startDet = state == IDLE && armed && !rxSync;
    sampleNow = tick && tickCnt == ((state == START) ? 4'd7 : 4'd15);
    stopOk = state == STOP && sampleNow && rxSync;
    stopBad = state == STOP && sampleNow && !rxSync;
    wordDone = stopOk && pending;
    gapExpired = pending && state == IDLE && !startDet && tick && gapCnt == GW'(GAP_TICKS - 1);
    stateNext = state;
    unique case (state)
      IDLE:  stateNext = startDet ? START : IDLE;
      START: stateNext = sampleNow ? (rxSync ? IDLE : DATA) : START;
      DATA:  stateNext = (sampleNow && bitCnt == 3'd7) ? STOP : DATA;
      STOP:  stateNext = sampleNow ? IDLE : STOP;
    endcase
  end
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else state <= stateNext;
  // armed only once a genuine high has passed the synchronizer, so a line held low
  // across reset or a bad stop bit is never mistaken for a start bit
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
      syncFill <= '0;
      armed <= 1'b0;
      tickCnt <= '0;
      bitCnt <= '0;
      shiftReg <= '0;
      lowByte <= '0;
      pending <= 1'b0;
      gapCnt <= '0;
    end else begin
      rxMeta <= Rx;
      rxSync <= rxMeta;
      syncFill <= {syncFill[0], 1'b1};
      armed <= (state == IDLE) && (armed || (rxSync && syncFill[1]));
      tickCnt <= (startDet || sampleNow) ? '0 : tick ? tickCnt + 4'd1 : tickCnt;
      bitCnt <= (state != DATA) ? '0 : sampleNow ? bitCnt + 3'd1 : bitCnt;
      if (state == DATA && sampleNow) shiftReg <= {rxSync, shiftReg[7:1]};
      if (stopOk && !pending) lowByte <= shiftReg;
      pending <= (stopBad || gapExpired) ? 1'b0 : stopOk ? !pending : pending;
      gapCnt <= (state == IDLE && pending && !gapExpired) ? (tick ? gapCnt + 1'b1 : gapCnt) : '0;
    end
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      Valid <= 1'b0;
      DataOut <= '0;
      FrameError <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      FrameError <= stopBad;
      Overrun <= wordDone && Valid && !Ack;
      if (wordDone && (!Valid || Ack)) begin
        DataOut <= {shiftReg, lowByte};
        Valid <= 1'b1;
      end else if (Ack) Valid <= 1'b0;
    end
endmodule

// File: tb/tb_uart_word_rx.sv
// tb_uart_word_rx: directed UART word reception with a queue-based scoreboard
module tb_uart_word_rx;
  localparam int TDIV = 4;
  localparam int BIT = 16 * TDIV;
  localparam logic [1:0] K_WORD = 2'd0, K_FERR = 2'd1, K_OVR = 2'd2;
  typedef struct {logic [1:0] kind; logic [15:0] data;} exp_t;
  logic Clock = 1'b0, Reset_n = 1'b0, Rx = 1'b1, Ack = 1'b0;
  logic Valid, FrameError, Overrun;
  logic [15:0] DataOut;
  exp_t sb[$];
  int nVec = 0, nMis = 0;
  logic prevValid = 1'b0;
  logic [15:0] prevData = '0;

  uart_word_rx #(.TICK_DIV(TDIV), .GAP_BITS(32)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Rx(Rx), .Ack(Ack),
    .Valid(Valid), .DataOut(DataOut), .FrameError(FrameError), .Overrun(Overrun)
  );

  always #5 Clock = ~Clock;

  task automatic expectEv(input logic [1:0] k, input logic [15:0] d);
    sb.push_back('{kind: k, data: d});
  endtask

  task automatic checkVal(input string name, input logic [15:0] got, input logic [15:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic popCheck(input string name, input logic [1:0] k, input logic [15:0] d);
    exp_t e;
    nVec++;
    if (sb.size() == 0) begin
      nMis++;
      $display("FAIL %s: got unexpected event kind %0d data %h, expected no event", name, k, d);
    end else begin
      e = sb.pop_front();
      if (e.kind !== k || e.data !== d) begin
        nMis++;
        $display("FAIL %s: got kind %0d data %h, expected kind %0d data %h", name, k, d, e.kind, e.data);
      end
    end
  endtask

  always @(negedge Clock) begin
    if (Reset_n) begin
      if (FrameError) popCheck("frame_error", K_FERR, 16'h0000);
      if (Overrun) popCheck("overrun", K_OVR, DataOut);
      if (Valid && (!prevValid || DataOut != prevData)) popCheck("word", K_WORD, DataOut);
    end
    prevValid <= Valid;
    prevData <= DataOut;
  end

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    Rx = 1'b0;
    repeat (BIT) @(negedge Clock);
    for (int i = 0; i < 8; i++) begin
      Rx = b[i];
      repeat (BIT) @(negedge Clock);
    end
    Rx = stopBit;
    repeat (BIT) @(negedge Clock);
    Rx = 1'b1;
  endtask

  task automatic waitValid(input string name);
    int n;
    n = 0;
    while (!Valid && n < 4 * BIT) begin
      @(negedge Clock);
      n++;
    end
    checkVal({name, "_valid"}, {15'd0, Valid}, 16'd1);
  endtask

  task automatic ackPulse(input string name);
    Ack = 1'b1;
    @(negedge Clock);
    Ack = 1'b0;
    checkVal({name, "_valid_fall"}, {15'd0, Valid}, 16'd0);
  endtask

  task automatic checkReset(input string name);
    checkVal({name, "_valid"}, {15'd0, Valid}, 16'd0);
    checkVal({name, "_data"}, DataOut, 16'h0000);
    checkVal({name, "_ferr"}, {15'd0, FrameError}, 16'd0);
    checkVal({name, "_ovr"}, {15'd0, Overrun}, 16'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) @(negedge Clock);
    checkReset("reset");
    Reset_n = 1'b1;
    repeat (BIT) @(negedge Clock);
    // basic word
    sendByte(8'h34, 1'b1);
    expectEv(K_WORD, 16'h1234);
    sendByte(8'h12, 1'b1);
    waitValid("w1234");
    checkVal("w1234_data", DataOut, 16'h1234);
    ackPulse("w1234");
    // short glitch is rejected silently
    Rx = 1'b0;
    repeat (3 * TDIV) @(negedge Clock);
    Rx = 1'b1;
    repeat (3 * BIT) @(negedge Clock);
    checkVal("glitch_valid", {15'd0, Valid}, 16'd0);
    // bad stop bit drops the pending low byte too
    sendByte(8'h99, 1'b1);
    expectEv(K_FERR, 16'h0000);
    sendByte(8'hAA, 1'b0);
    repeat (BIT) @(negedge Clock);
    sendByte(8'h01, 1'b1);
    expectEv(K_WORD, 16'h0201);
    sendByte(8'h02, 1'b1);
    waitValid("w0201");
    ackPulse("w0201");
    // long idle discards pending low byte
    sendByte(8'h55, 1'b1);
    repeat (40 * BIT) @(negedge Clock);
    sendByte(8'h0F, 1'b1);
    expectEv(K_WORD, 16'hF00F);
    sendByte(8'hF0, 1'b1);
    waitValid("wf00f");
    ackPulse("wf00f");
    // overrun when not acked
    sendByte(8'hEF, 1'b1);
    expectEv(K_WORD, 16'hBEEF);
    sendByte(8'hBE, 1'b1);
    waitValid("wbeef");
    sendByte(8'hFE, 1'b1);
    expectEv(K_OVR, 16'hBEEF);
    sendByte(8'hCA, 1'b1);
    checkVal("ovr_data_held", DataOut, 16'hBEEF);
    checkVal("ovr_valid_held", {15'd0, Valid}, 16'd1);
    ackPulse("ovr");
    // ack on the completion cycle reloads
    sendByte(8'hEF, 1'b1);
    expectEv(K_WORD, 16'hBEEF);
    sendByte(8'hBE, 1'b1);
    waitValid("wbeef2");
    sendByte(8'hFE, 1'b1);
    expectEv(K_WORD, 16'hCAFE);
    fork
      sendByte(8'hCA, 1'b1);
      begin
        n = 0;
        while (!dut.wordDone && n < 12 * BIT) begin
          @(negedge Clock);
          n++;
        end
        checkVal("cafe_completion_seen", {15'd0, dut.wordDone}, 16'd1);
        Ack = 1'b1;
        @(negedge Clock);
        Ack = 1'b0;
      end
    join
    checkVal("cafe_data", DataOut, 16'hCAFE);
    checkVal("cafe_valid_kept", {15'd0, Valid}, 16'd1);
    // reset mid-frame with the line held low across release
    Rx = 1'b0;
    repeat (2 * BIT + BIT / 2) @(negedge Clock);
    Reset_n = 1'b0;
    @(negedge Clock);
    checkReset("midreset");
    repeat (4) @(negedge Clock);
    Reset_n = 1'b1;
    repeat (2 * BIT) @(negedge Clock);
    Rx = 1'b1;
    repeat (12 * BIT) @(negedge Clock);
    checkVal("midreset_idle_valid", {15'd0, Valid}, 16'd0);
    sendByte(8'h78, 1'b1);
    expectEv(K_WORD, 16'h5678);
    sendByte(8'h56, 1'b1);
    waitValid("w5678");
    ackPulse("w5678");
    repeat (2 * BIT) @(negedge Clock);
    checkVal("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule

// File: doc/uart_word_rx.md
UART_WORD_RX -- requirements
Module: uart_word_rx

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter TICK_DIV, default 27, SHALL set the Clock cycles per oversample tick (50 MHz / (115200*16)).
REQ-003 Parameter GAP_BITS, default 32, SHALL set the maximum idle gap, in bit periods, allowed between the low and high byte of one word.
REQ-004 Port Clock SHALL be an input, 1 bit, the system clock; all state SHALL be updated on its rising edge.
REQ-005 Port Reset_n SHALL be an input, 1 bit, the asynchronous active-low reset.
REQ-006 Port Rx SHALL be an input, 1 bit, the asynchronous serial line, idle high.
REQ-007 Port Ack SHALL be an input, 1 bit, asserted by the consumer to take the held word.
REQ-008 Port Valid SHALL be an output, 1 bit, high while DataOut holds an unconsumed word.
REQ-009 Port DataOut SHALL be an output, 16 bits, the last assembled word.
REQ-010 Port FrameError SHALL be an output, 1 bit, a one-cycle pulse on a bad stop bit.
REQ-011 Port Overrun SHALL be an output, 1 bit, a one-cycle pulse when a completed word is dropped.

Function
REQ-012 Rx SHALL pass through a 2-flop synchronizer before any use.
REQ-013 The tick generator SHALL pulse once every TICK_DIV Clock cycles, free-running; there SHALL be 16 ticks per bit.
REQ-014 The FSM SHALL have four states: IDLE, START, DATA and STOP.
REQ-015 In IDLE, a sampled low on the synchronized Rx SHALL move the FSM to START and clear the tick count.
REQ-016 In START, at tick 7 the FSM SHALL go to DATA if Rx is low, and return to IDLE if Rx is high (glitch rejection, nothing reported).
REQ-017 In DATA, the FSM SHALL sample 8 bits, LSB first, each at the 16th tick after the previous sample point, then go to STOP.
REQ-018 In STOP, if Rx is high at the 16th tick, the byte SHALL be accepted; if Rx is low, FrameError SHALL pulse, the byte and any pending low byte SHALL be discarded, and the FSM SHALL return to IDLE once Rx is high.
REQ-019 Bytes SHALL be paired with the low byte first: the first accepted byte sets a pending flag, and the second completes the word {high, low}.
REQ-020 If the pending flag is set and no start bit is detected within GAP_BITS*16 ticks, the pending low byte SHALL be silently discarded.
REQ-021 The word SHALL be loaded into DataOut, and Valid raised, on the Clock cycle after the high byte's stop sample (latency of one cycle).
REQ-022 Valid SHALL stay high and DataOut stable until a cycle with Ack=1; Valid SHALL fall in the next cycle, and Ack with Valid=0 SHALL be ignored.
REQ-023 If a word completes in a cycle with Ack=1 and Valid=1, the new word SHALL load and Valid SHALL remain 1.
REQ-024 If a word completes while Valid=1 and Ack=0, the new word SHALL be dropped, DataOut SHALL be unchanged and Overrun SHALL pulse.
REQ-025 Reception SHALL continue independent of the state of Valid; the pairing SHALL never stall.

Reset
REQ-026 While Reset_n=0, the FSM SHALL be in IDLE, all counters and the pending flag cleared, and the synchronizer flops set to 1.
REQ-027 While Reset_n=0, the outputs SHALL be Valid=0, DataOut=16'h0000, FrameError=0 and Overrun=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; after release the block SHALL wait for Rx high in IDLE before detecting a start bit.

Structure
REQ-029 The shared package uart_pkg SHALL hold the rx_state_t enum, the OVERSAMPLE=16 constant and the default TICK_DIV.
REQ-030 The tick divider SHALL be the sub-module uart_tick_gen (ports Clock, Reset_n, Tick), reusable by a matching transmitter.

Verification
REQ-031 Send bytes 8'h34 then 8'h12 at 115200 baud -> Valid=1 with DataOut=16'h1234; Ack -> Valid=0 on the next cycle.
REQ-032 Send a 3-tick low glitch on Rx -> the FSM returns to IDLE and Valid, FrameError and Overrun stay 0.
REQ-033 Send 8'hAA with the stop bit held low -> one FrameError pulse; then 8'h01 and 8'h02 -> DataOut=16'h0201.
REQ-034 Send 8'h55, idle for 40 bit times, then send 8'h0F and 8'hF0 -> DataOut=16'hF00F, with 8'h55 discarded.
REQ-035 Send word 16'hBEEF with no Ack, then word 16'hCAFE -> one Overrun pulse and DataOut stays 16'hBEEF; repeat with Ack on the completion cycle -> DataOut=16'hCAFE and Valid stays 1.
REQ-036 Assert Reset_n=0 during DATA of a low byte, release, then send 8'h78 and 8'h56 -> DataOut=16'h5678.
